dm_responder: RTL and testbench

//  Data-memory responder for the pipelined core's M-stage bus (m_data_addr/wdata/byteen, m_inst_addr).

---
 rtl/dm_responder.sv | 144 ++++++++++++++
 tb/tb_dm_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - M-stage data-memory responder with write-trace FIFO; optional macro DM_RANGE_ERR_EN
module dm_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          MEM_WORDS  = 3072,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic [31:0] trc_pc,
    output logic [31:0] trc_addr,
    output logic [31:0] trc_data,
    output logic [3:0]  trc_byteen,
    output logic        trc_overflow,
    output logic        range_err
);

    localparam int          IDX_W = $clog2(MEM_WORDS);
    localparam int          PTR_W = $clog2(FIFO_DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam int          REC_W = 100;
    localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(4 * MEM_WORDS);

    // Memory contents start at zero at power-up; reset intentionally leaves them alone.
    logic [31:0]      mem [MEM_WORDS] = '{default: '0};
    logic [REC_W-1:0] fifo_mem [FIFO_DEPTH];

    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             wr_req;
    logic             wr_accept;
    logic [31:0]      cur_word;
    logic [31:0]      merged;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic [REC_W-1:0] head;

    assign offset    = m_data_addr - BASE_ADDR;
    assign idx       = IDX_W'(offset >> 2);
    assign in_range  = (m_data_addr >= BASE_ADDR) && ({1'b0, m_data_addr} < LIMIT);
    assign wr_req    = (m_data_byteen != 4'b0000);
    assign wr_accept = wr_req && in_range;

    // Combinational word read; the merge below also uses this pre-write value.
    always_comb begin
        cur_word = 32'h0;
        if (in_range) begin
            cur_word = mem[idx];
        end
    end

    assign m_data_rdata = cur_word;

    // Byte-lane merge of write data over the currently stored word.
    always_comb begin
        merged = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) begin
                merged[8*i +: 8] = m_data_wdata[8*i +: 8];
            end
        end
    end

    // Memory update; a write in a cycle where reset is held low is discarded.
    always_ff @(posedge clk) begin
        if (reset && wr_accept) begin
            mem[idx] <= merged;
        end
    end

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop     = trc_valid && trc_ready;
    assign push_ok = wr_accept && (!full || pop);

    // Trace record storage; stale entries are harmless because pointers govern visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= {m_inst_addr, m_data_addr[31:2], 2'b00, merged, m_data_byteen};
        end
    end

    // FIFO pointers and occupancy; a full FIFO that pops can still take the new record.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: a write arrived while full and nothing was leaving.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trc_overflow <= 1'b0;
        end else if (wr_accept && full && !pop) begin
            trc_overflow <= 1'b1;
        end
    end

    assign trc_valid  = (count != '0);
    assign head       = trc_valid ? fifo_mem[rd_ptr] : '0;
    assign trc_pc     = head[99:68];
    assign trc_addr   = head[67:36];
    assign trc_data   = head[35:4];
    assign trc_byteen = head[3:0];

`ifdef DM_RANGE_ERR_EN
    // Sticky flag for any enabled write that falls outside the memory window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            range_err <= 1'b0;
        end else if (wr_req && !in_range) begin
            range_err <= 1'b1;
        end
    end
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed self-checking bench for dm_responder
module tb_dm_responder;

    logic        clk;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        trc_valid;
    logic        trc_ready;
    logic [31:0] trc_pc;
    logic [31:0] trc_addr;
    logic [31:0] trc_data;
    logic [3:0]  trc_byteen;
    logic        trc_overflow;
    logic        range_err;

    int n_checks;
    int n_fail;

    dm_responder dut (
        .clk           (clk),
        .reset         (reset),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_inst_addr   (m_inst_addr),
        .m_data_rdata  (m_data_rdata),
        .trc_valid     (trc_valid),
        .trc_ready     (trc_ready),
        .trc_pc        (trc_pc),
        .trc_addr      (trc_addr),
        .trc_data      (trc_data),
        .trc_byteen    (trc_byteen),
        .trc_overflow  (trc_overflow),
        .range_err     (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input logic [31:0] pc);
        m_data_addr   = addr;
        m_data_wdata  = data;
        m_data_byteen = be;
        m_inst_addr   = pc;
        @(posedge clk);
        #1;
        m_data_byteen = 4'h0;
    endtask

    task automatic do_pop();
        trc_ready = 1'b1;
        @(posedge clk);
        #1;
        trc_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", trc_valid); end
        n_checks++;
        if (trc_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", trc_overflow); end
        n_checks++;
        if (range_err !== 1'b0) begin n_fail++; $display("FAIL reset_range_err: got %b want 0", range_err); end
        n_checks++;
        if ({trc_pc, trc_addr, trc_data, trc_byteen} !== 100'h0) begin
            n_fail++; $display("FAIL reset_trace_fields: got %h want 0", {trc_pc, trc_addr, trc_data, trc_byteen});
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_write_word();
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 32'h3000);
        m_data_addr = 32'h10;
        #1;
        n_checks++;
        if (m_data_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_read: got %h want DEADBEEF", m_data_rdata); end
        n_checks++;
        if (trc_valid !== 1'b1) begin n_fail++; $display("FAIL word_trc_valid: got %b want 1", trc_valid); end
        n_checks++;
        if ({trc_pc, trc_addr, trc_data, trc_byteen} !== {32'h3000, 32'h10, 32'hDEADBEEF, 4'hF}) begin
            n_fail++; $display("FAIL word_trace: got %h %h %h %h want 3000 10 DEADBEEF F", trc_pc, trc_addr, trc_data, trc_byteen);
        end
    endtask

    task automatic test_byte_merge();
        m_data_addr   = 32'h11;
        m_data_wdata  = 32'h0000AB00;
        m_data_byteen = 4'b0010;
        m_inst_addr   = 32'h3004;
        #1;
        n_checks++;
        if (m_data_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL merge_read_during_write: got %h want DEADBEEF", m_data_rdata); end
        @(posedge clk);
        #1;
        m_data_byteen = 4'h0;
        #1;
        n_checks++;
        if (m_data_rdata !== 32'hDEADABEF) begin n_fail++; $display("FAIL merge_read: got %h want DEADABEF", m_data_rdata); end
        n_checks++;
        if (trc_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL merge_head_held: got %h want DEADBEEF", trc_data); end
        do_pop();
        n_checks++;
        if ({trc_pc, trc_addr, trc_data, trc_byteen} !== {32'h3004, 32'h10, 32'hDEADABEF, 4'b0010}) begin
            n_fail++; $display("FAIL merge_trace: got %h %h %h %h want 3004 10 DEADABEF 2", trc_pc, trc_addr, trc_data, trc_byteen);
        end
        do_pop();
        n_checks++;
        if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL merge_drained: got %b want 0", trc_valid); end
    endtask

    task automatic test_last_word();
        do_write(32'h2FFC, 32'hCAFEF00D, 4'hF, 32'h3008);
        m_data_addr = 32'h2FFE;
        #1;
        n_checks++;
        if (m_data_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL last_word_read: got %h want CAFEF00D", m_data_rdata); end
        n_checks++;
        if (trc_addr !== 32'h2FFC) begin n_fail++; $display("FAIL last_word_trc_addr: got %h want 2FFC", trc_addr); end
        do_pop();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            do_write(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF, 32'h4000 + 32'(4 * i));
            n_checks++;
            if (trc_overflow !== (i == 8)) begin n_fail++; $display("FAIL ovf_flag_%0d: got %b want %b", i, trc_overflow, i == 8); end
        end
        n_checks++;
        if (trc_pc !== 32'h4000) begin n_fail++; $display("FAIL ovf_head_pc: got %h want 4000", trc_pc); end
        trc_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (!trc_valid || trc_data !== 32'h1000 + 32'(i)) begin
                n_fail++; $display("FAIL ovf_drain_%0d: valid %b data %h want 1 %h", i, trc_valid, trc_data, 32'h1000 + 32'(i));
            end
            @(posedge clk);
            #1;
        end
        trc_ready = 1'b0;
        n_checks++;
        if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", trc_valid); end
        n_checks++;
        if (trc_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", trc_overflow); end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        for (int i = 1; i <= 8; i++) begin
            do_write(32'h200 + 32'(4 * i), 32'h2000 + 32'(i), 4'hF, 32'h5000 + 32'(i));
        end
        trc_ready     = 1'b1;
        m_data_addr   = 32'h200 + 32'd36;
        m_data_wdata  = 32'h2009;
        m_data_byteen = 4'hF;
        m_inst_addr   = 32'h5009;
        @(posedge clk);
        #1;
        m_data_byteen = 4'h0;
        n_checks++;
        if (trc_overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overflow: got %b want 0", trc_overflow); end
        for (int i = 2; i <= 9; i++) begin
            n_checks++;
            if (!trc_valid || trc_data !== 32'h2000 + 32'(i)) begin
                n_fail++; $display("FAIL b2b_drain_%0d: valid %b data %h want 1 %h", i, trc_valid, trc_data, 32'h2000 + 32'(i));
            end
            @(posedge clk);
            #1;
        end
        trc_ready = 1'b0;
        n_checks++;
        if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", trc_valid); end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) begin
            do_write(32'h300 + 32'(4 * i), 32'h3300 + 32'(i), 4'hF, 32'h6000);
        end
        do_pop();
        #1;
        reset         = 1'b0;
        m_data_addr   = 32'h10;
        m_data_wdata  = 32'h0;
        m_data_byteen = 4'hF;
        #1;
        n_checks++;
        if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", trc_valid); end
        n_checks++;
        if ({trc_overflow, range_err} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_flags: got %b want 00", {trc_overflow, range_err}); end
        n_checks++;
        if (trc_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_trc_data: got %h want 0", trc_data); end
        @(posedge clk);
        #1;
        m_data_byteen = 4'h0;
        reset         = 1'b1;
        #1;
        n_checks++;
        if (m_data_rdata !== 32'hDEADABEF) begin n_fail++; $display("FAIL rst_mid_mem_kept: got %h want DEADABEF", m_data_rdata); end
        n_checks++;
        if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_write_lost: got %b want 0", trc_valid); end
    endtask

    task automatic test_range();
        logic exp_err;
`ifdef DM_RANGE_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_write(32'h3000, 32'h55555555, 4'hF, 32'h7000);
        m_data_addr = 32'h3000;
        #1;
        n_checks++;
        if (m_data_rdata !== 32'h0) begin n_fail++; $display("FAIL range_read_oor: got %h want 0", m_data_rdata); end
        m_data_addr = 32'h10;
        #1;
        n_checks++;
        if (m_data_rdata !== 32'hDEADABEF) begin n_fail++; $display("FAIL range_mem_kept: got %h want DEADABEF", m_data_rdata); end
        m_data_addr = 32'h2FFC;
        #1;
        n_checks++;
        if (m_data_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL range_last_kept: got %h want CAFEF00D", m_data_rdata); end
        n_checks++;
        if (trc_valid !== 1'b0) begin n_fail++; $display("FAIL range_no_trace: got %b want 0", trc_valid); end
        n_checks++;
        if (range_err !== exp_err) begin n_fail++; $display("FAIL range_err_flag: got %b want %b", range_err, exp_err); end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        trc_ready     = 1'b0;
        m_data_addr   = 32'h0;
        m_data_wdata  = 32'h0;
        m_data_byteen = 4'h0;
        m_inst_addr   = 32'h0;
        test_reset();
        test_write_word();
        test_byte_merge();
        test_last_word();
        test_overflow();
        test_back_to_back();
        test_reset_mid_drain();
        test_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
